// File: rtl/iic_cmd_sequencer_if.sv
// Command-table and iic_master bus of iic_cmd_sequencer.
// The sequencer uses the master modport; the ROM/iic_master side uses slave.
interface iic_cmd_sequencer_if;
    logic       start_i;
    logic [7:0] cmd_idx_o;
    logic [7:0] cmd_reg_i;
    logic [7:0] cmd_dat_i;
    logic       iic_flag_o;
    logic       iic_rst_o;
    logic [6:0] iic_slv_addr_o;
    logic [7:0] iic_reg_addr_o;
    logic [7:0] iic_data_o;
    logic       iic_ready_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [7:0] err_idx_o;

    modport master (
        input  start_i, cmd_reg_i, cmd_dat_i, iic_ready_i,
        output cmd_idx_o, iic_flag_o, iic_rst_o, iic_slv_addr_o,
               iic_reg_addr_o, iic_data_o, busy_o, done_o, err_o, err_idx_o
    );

    modport slave (
        output start_i, cmd_reg_i, cmd_dat_i, iic_ready_i,
        input  cmd_idx_o, iic_flag_o, iic_rst_o, iic_slv_addr_o,
               iic_reg_addr_o, iic_data_o, busy_o, done_o, err_o, err_idx_o
    );
endinterface

// File: rtl/iic_cmd_sequencer.sv
// Walks a {reg_addr, data} table and issues one IIC write per entry on iic_master.
// reg_addr 8'hFF marks a delay entry of data*DLY_UNIT cycles instead of a transfer.
module iic_cmd_sequencer #(
    parameter int         NUM_CMDS = 16,
    parameter logic [6:0] SLV_ADDR = 7'h3C,
    parameter int         TIMEOUT  = 4096,
    parameter int         RST_CYC  = 2,
    parameter int         GAP_CYC  = 8,
    parameter int         DLY_UNIT = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    iic_cmd_sequencer_if.master bus
);

    localparam int MAX_CNT = (TIMEOUT > 255 * DLY_UNIT) ? TIMEOUT : 255 * DLY_UNIT;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] UNIT     = CNT_W'(DLY_UNIT);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_CMDS - 1);
    localparam logic [7:0]       DLY_REG  = 8'hFF;

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, KICK, WAIT, MRST, GAP, DLY, DONE, ERR
    } state_t;

    state_t           state;
    logic [7:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             entry_done;

    // A zero-length delay entry finishes straight out of LOAD so it costs no DLY cycles.
    always_comb begin
        entry_done = 1'b0;
        case (state)
            GAP:     entry_done = (cnt == GAP_LAST);
            DLY:     entry_done = (cnt == ONE);
            LOAD:    entry_done = (bus.cmd_reg_i == DLY_REG) && (bus.cmd_dat_i == 8'h00);
            default: entry_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state              <= IDLE;
            idx                <= 8'h00;
            cnt                <= '0;
            bus.cmd_idx_o      <= 8'h00;
            bus.iic_flag_o     <= 1'b0;
            bus.iic_rst_o      <= 1'b0;
            bus.iic_slv_addr_o <= SLV_ADDR;
            bus.iic_reg_addr_o <= 8'h00;
            bus.iic_data_o     <= 8'h00;
            bus.busy_o         <= 1'b0;
            bus.done_o         <= 1'b0;
            bus.err_o          <= 1'b0;
            bus.err_idx_o      <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    // The master also needs its reset after a timed-out transfer.
                    if (state == ERR && bus.iic_rst_o) begin
                        if (cnt == RST_LAST)
                            bus.iic_rst_o <= 1'b0;
                        else
                            cnt <= cnt + ONE;
                    end
                    if (bus.start_i) begin
                        state          <= FETCH;
                        idx            <= 8'h00;
                        cnt            <= '0;
                        bus.cmd_idx_o  <= 8'h00;
                        bus.iic_rst_o  <= 1'b0;
                        bus.busy_o     <= 1'b1;
                        bus.done_o     <= 1'b0;
                        bus.err_o      <= 1'b0;
                        bus.err_idx_o  <= 8'h00;
                    end
                end

                FETCH: state <= LOAD;

                LOAD: begin
                    if (bus.cmd_reg_i == DLY_REG) begin
                        cnt   <= CNT_W'(bus.cmd_dat_i) * UNIT;
                        state <= DLY;
                    end else begin
                        bus.iic_reg_addr_o <= bus.cmd_reg_i;
                        bus.iic_data_o     <= bus.cmd_dat_i;
                        bus.iic_flag_o     <= 1'b1;
                        state              <= KICK;
                    end
                end

                KICK: begin
                    bus.iic_flag_o <= 1'b0;
                    cnt            <= '0;
                    state          <= WAIT;
                end

                // Ready is checked first so a last-cycle ready still counts as success.
                WAIT: begin
                    if (bus.iic_ready_i) begin
                        bus.iic_rst_o <= 1'b1;
                        cnt           <= '0;
                        state         <= MRST;
                    end else if (cnt == TO_LAST) begin
                        bus.iic_rst_o <= 1'b1;
                        bus.err_o     <= 1'b1;
                        bus.err_idx_o <= idx;
                        bus.busy_o    <= 1'b0;
                        cnt           <= '0;
                        state         <= ERR;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                MRST: begin
                    if (cnt == RST_LAST) begin
                        bus.iic_rst_o <= 1'b0;
                        cnt           <= '0;
                        state         <= GAP;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                GAP: cnt <= cnt + ONE;

                DLY: cnt <= cnt - ONE;

                default: state <= IDLE;
            endcase

            // Overrides the per-state transition on the last cycle of an entry.
            if (entry_done) begin
                if (idx == LAST_IDX) begin
                    bus.busy_o <= 1'b0;
                    bus.done_o <= 1'b1;
                    state      <= DONE;
                end else begin
                    idx           <= idx + 8'd1;
                    bus.cmd_idx_o <= idx + 8'd1;
                    state         <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_iic_cmd_sequencer.sv
// Directed bench for iic_cmd_sequencer with a registered command ROM and a
// behavioural iic_master that raises ready a programmable number of cycles after flag.
module tb_iic_cmd_sequencer;

    localparam int NUM_CMDS = 3;
    localparam int TIMEOUT  = 64;
    localparam int RST_CYC  = 2;
    localparam int GAP_CYC  = 8;
    localparam int DLY_UNIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iic_cmd_sequencer_if bus();

    iic_cmd_sequencer #(
        .NUM_CMDS (NUM_CMDS),
        .SLV_ADDR (7'h3C),
        .TIMEOUT  (TIMEOUT),
        .RST_CYC  (RST_CYC),
        .GAP_CYC  (GAP_CYC),
        .DLY_UNIT (DLY_UNIT)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Command ROM with one cycle of read latency.
    logic [7:0] romReg [4];
    logic [7:0] romDat [4];
    int         readyDelay [4];

    always @(posedge clk) begin
        bus.cmd_reg_i <= romReg[bus.cmd_idx_o[1:0]];
        bus.cmd_dat_i <= romDat[bus.cmd_idx_o[1:0]];
    end

    // Master model: parks with ready high until reset; delay 0 means it never answers.
    int   mCnt;
    int   mDelay;
    logic mBusy;

    always @(posedge clk) begin
        if (reset || bus.iic_rst_o) begin
            mBusy           <= 1'b0;
            mCnt            <= 0;
            mDelay          <= 0;
            bus.iic_ready_i <= 1'b0;
        end else if (bus.iic_flag_o) begin
            mDelay <= readyDelay[bus.cmd_idx_o[1:0]];
            mBusy  <= (readyDelay[bus.cmd_idx_o[1:0]] != 0);
            mCnt   <= 1;
        end else if (mBusy) begin
            if (mCnt == mDelay) begin
                bus.iic_ready_i <= 1'b1;
                mBusy           <= 1'b0;
            end else begin
                mCnt <= mCnt + 1;
            end
        end
    end

    // Running monitor; scenarios compare deltas against a snapshot taken before they start.
    int         cycleNo     = 0;
    int         flagRises   = 0;
    int         flagCycles  = 0;
    int         rstPulses   = 0;
    int         rstRun      = 0;
    int         busyCycles  = 0;
    logic       prevFlag    = 1'b0;
    logic [7:0] prevIdx     = 8'h00;
    logic [7:0] flagReg [64];
    logic [7:0] flagDat [64];
    int         rstLen  [64];
    int         idxChangeCycle [4];

    always @(negedge clk) begin
        cycleNo++;
        if (bus.busy_o === 1'b1) busyCycles++;
        if (bus.iic_flag_o === 1'b1) begin
            flagCycles++;
            if (!prevFlag && flagRises < 64) begin
                flagReg[flagRises] = bus.iic_reg_addr_o;
                flagDat[flagRises] = bus.iic_data_o;
                flagRises++;
            end
        end
        prevFlag = (bus.iic_flag_o === 1'b1);
        if (bus.iic_rst_o === 1'b1) begin
            rstRun++;
        end else if (rstRun != 0) begin
            if (rstPulses < 64) rstLen[rstPulses] = rstRun;
            rstPulses++;
            rstRun = 0;
        end
        if (bus.cmd_idx_o !== prevIdx) begin
            idxChangeCycle[bus.cmd_idx_o[1:0]] = cycleNo;
            prevIdx = bus.cmd_idx_o;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic loadTable(input logic [7:0] r0, d0, r1, d1, r2, d2);
        romReg[0] = r0; romDat[0] = d0;
        romReg[1] = r1; romDat[1] = d1;
        romReg[2] = r2; romDat[2] = d2;
        romReg[3] = 8'h00; romDat[3] = 8'h00;
    endtask

    task automatic setDelays(input int a, b, c);
        readyDelay[0] = a;
        readyDelay[1] = b;
        readyDelay[2] = c;
        readyDelay[3] = 0;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n = 0;
        while (bus.busy_o === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(bus.busy_o), 32'h0);
    endtask

    task automatic waitFlags(input string tag, input int target, input int limit);
        int n = 0;
        while (flagRises < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(flagRises >= target), 32'h1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},   32'(bus.busy_o),         32'h0);
        checkOutput({tag, "_done"},   32'(bus.done_o),         32'h0);
        checkOutput({tag, "_err"},    32'(bus.err_o),          32'h0);
        checkOutput({tag, "_errIdx"}, 32'(bus.err_idx_o),      32'h0);
        checkOutput({tag, "_flag"},   32'(bus.iic_flag_o),     32'h0);
        checkOutput({tag, "_rst"},    32'(bus.iic_rst_o),      32'h0);
        checkOutput({tag, "_slv"},    32'(bus.iic_slv_addr_o), 32'h3C);
        checkOutput({tag, "_idx"},    32'(bus.cmd_idx_o),      32'h0);
        checkOutput({tag, "_reg"},    32'(bus.iic_reg_addr_o), 32'h0);
        checkOutput({tag, "_dat"},    32'(bus.iic_data_o),     32'h0);
    endtask

    int fBase, cBase, rBase, bBase;

    task automatic snapshot();
        fBase = flagRises;
        cBase = flagCycles;
        rBase = rstPulses;
        bBase = busyCycles;
    endtask

    initial begin
        logic [7:0] expReg [3];
        logic [7:0] expDat [3];
        expReg = '{8'h00, 8'h81, 8'hAF};
        expDat = '{8'hAE, 8'h7F, 8'h00};
        bus.start_i = 1'b0;
        loadTable(8'h00, 8'hAE, 8'h81, 8'h7F, 8'hAF, 8'h00);
        setDelays(40, 40, 40);

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;

        $display("[TB] three-entry init table");
        snapshot();
        applyStimulus();
        waitIdle("A_idle", 1000);
        checkOutput("A_flags",   32'(flagRises - fBase),  32'd3);
        checkOutput("A_flagLen", 32'(flagCycles - cBase), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("A_reg%0d", i), 32'(flagReg[fBase + i]), 32'(expReg[i]));
            checkOutput($sformatf("A_dat%0d", i), 32'(flagDat[fBase + i]), 32'(expDat[i]));
            checkOutput($sformatf("A_rstLen%0d", i), 32'(rstLen[rBase + i]), 32'd2);
        end
        checkOutput("A_rstPulses", 32'(rstPulses - rBase), 32'd3);
        checkOutput("A_busyCyc",   32'(busyCycles - bBase), 32'd162);
        checkOutput("A_done",      32'(bus.done_o), 32'h1);
        checkOutput("A_err",       32'(bus.err_o),  32'h0);
        checkOutput("A_slv",       32'(bus.iic_slv_addr_o), 32'h3C);

        $display("[TB] delay entry in slot 1");
        loadTable(8'h00, 8'hAE, 8'hFF, 8'h03, 8'hAF, 8'h00);
        snapshot();
        applyStimulus();
        waitIdle("B_idle", 1000);
        checkOutput("B_flags",   32'(flagRises - fBase), 32'd2);
        checkOutput("B_reg0",    32'(flagReg[fBase]),     32'h00);
        checkOutput("B_reg2",    32'(flagReg[fBase + 1]), 32'hAF);
        checkOutput("B_dat2",    32'(flagDat[fBase + 1]), 32'h00);
        checkOutput("B_idxGap",  32'(idxChangeCycle[2] - idxChangeCycle[1]), 32'd14);
        checkOutput("B_busyCyc", 32'(busyCycles - bBase), 32'd122);
        checkOutput("B_rstPulses", 32'(rstPulses - rBase), 32'd2);
        checkOutput("B_done",    32'(bus.done_o), 32'h1);

        $display("[TB] ready on the last WAIT cycle");
        loadTable(8'h00, 8'hAE, 8'h81, 8'h7F, 8'hAF, 8'h00);
        setDelays(63, 63, 63);
        snapshot();
        applyStimulus();
        waitIdle("D1_idle", 1000);
        checkOutput("D1_err",     32'(bus.err_o),  32'h0);
        checkOutput("D1_done",    32'(bus.done_o), 32'h1);
        checkOutput("D1_flags",   32'(flagRises - fBase), 32'd3);
        checkOutput("D1_busyCyc", 32'(busyCycles - bBase), 32'd231);

        $display("[TB] ready one cycle too late");
        setDelays(64, 40, 40);
        snapshot();
        applyStimulus();
        waitIdle("D2_idle", 1000);
        checkOutput("D2_err",    32'(bus.err_o),     32'h1);
        checkOutput("D2_errIdx", 32'(bus.err_idx_o), 32'h0);
        checkOutput("D2_done",   32'(bus.done_o),    32'h0);
        checkOutput("D2_flags",  32'(flagRises - fBase), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("D2_rstPulses", 32'(rstPulses - rBase), 32'd1);
        checkOutput("D2_rstLen",    32'(rstLen[rBase]),     32'd2);

        $display("[TB] master never answers entry 1");
        setDelays(40, 0, 40);
        snapshot();
        applyStimulus();
        checkOutput("C_errCleared",    32'(bus.err_o),  32'h0);
        checkOutput("C_busyAfterStart", 32'(bus.busy_o), 32'h1);
        waitIdle("C_idle", 1000);
        checkOutput("C_err",    32'(bus.err_o),     32'h1);
        checkOutput("C_errIdx", 32'(bus.err_idx_o), 32'h1);
        checkOutput("C_done",   32'(bus.done_o),    32'h0);
        repeat (30) @(negedge clk);
        checkOutput("C_flags",      32'(flagRises - fBase), 32'd2);
        checkOutput("C_rstPulses",  32'(rstPulses - rBase), 32'd2);
        checkOutput("C_errRstLen",  32'(rstLen[rBase + 1]), 32'd2);
        setDelays(40, 40, 40);
        snapshot();
        applyStimulus();
        checkOutput("C2_errCleared", 32'(bus.err_o),     32'h0);
        checkOutput("C2_errIdx",     32'(bus.err_idx_o), 32'h0);
        checkOutput("C2_idx",        32'(bus.cmd_idx_o), 32'h0);
        waitIdle("C2_idle", 1000);
        checkOutput("C2_flags", 32'(flagRises - fBase), 32'd3);
        checkOutput("C2_reg0",  32'(flagReg[fBase]),    32'h00);
        checkOutput("C2_done",  32'(bus.done_o),        32'h1);

        $display("[TB] start during WAIT and in DONE");
        snapshot();
        applyStimulus();
        waitFlags("F_flag1", fBase + 2, 500);
        applyStimulus();
        checkOutput("F_idxKept",  32'(bus.cmd_idx_o), 32'h1);
        checkOutput("F_busyKept", 32'(bus.busy_o),    32'h1);
        waitIdle("F_idle", 1000);
        checkOutput("F_flags", 32'(flagRises - fBase), 32'd3);
        checkOutput("F_done",  32'(bus.done_o),        32'h1);
        snapshot();
        applyStimulus();
        checkOutput("F2_doneCleared", 32'(bus.done_o), 32'h0);
        checkOutput("F2_busy",        32'(bus.busy_o), 32'h1);
        waitIdle("F2_idle", 1000);
        checkOutput("F2_flags", 32'(flagRises - fBase), 32'd3);
        checkOutput("F2_done",  32'(bus.done_o),        32'h1);

        $display("[TB] reset during WAIT of entry 2");
        snapshot();
        applyStimulus();
        waitFlags("E_flag2", fBase + 3, 500);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetOutputs("E_reset");
        repeat (20) @(negedge clk);
        checkOutput("E_noFlags", 32'(flagRises - fBase), 32'd3);
        snapshot();
        applyStimulus();
        waitIdle("E_idle", 1000);
        checkOutput("E_flags", 32'(flagRises - fBase), 32'd3);
        checkOutput("E_reg0",  32'(flagReg[fBase]),    32'h00);
        checkOutput("E_dat0",  32'(flagDat[fBase]),    32'hAE);
        checkOutput("E_done",  32'(bus.done_o),        32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
